// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/memReady in, datapath controls and debug state out of the main control unit.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       memReady;
   logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
   logic [1:0] aluSrcB, pcSource, aluOp;
   logic [3:0] state;
   modport master (
      input  opcode, memReady,
      output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
             memToReg, regDst, regWrite, aluSrcA, illegalOp,
             aluSrcB, pcSource, aluOp, state
   );
   modport slave (
      output opcode, memReady,
      input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
             memToReg, regDst, regWrite, aluSrcA, illegalOp,
             aluSrcB, pcSource, aluOp, state
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control Moore FSM; MC_MEM_WAIT_EN adds memReady stalls.
module multicycle_control (
   input logic clk,
   input logic rst,
   multicycle_control_if.master bus
);
   localparam logic [3:0] INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                          MEMREAD = 4'd4, MEMWB = 4'd5, MEMWRITE = 4'd6, EXECUTE = 4'd7,
                          ALUWB = 4'd8, BRANCH = 4'd9, ADDIEXEC = 4'd10, ORIEXEC = 4'd11,
                          IMMWB = 4'd12, JUMP = 4'd13;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                          OP_J = 6'b000010;
   logic [3:0] st, nextSt;
   logic       isStore, ready, legalOp;
`ifdef MC_MEM_WAIT_EN
   assign ready = bus.memReady;
`else
   logic unusedMemReady;
   assign unusedMemReady = bus.memReady;
   assign ready = 1'b1;
`endif
   assign legalOp = bus.opcode inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_ORI, OP_J};
   assign bus.state = st;
   // opcode is only valid in DECODE, so lw/sw is remembered for the MEMADR branch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= INIT;
         isStore <= 1'b0;
      end else begin
         st <= nextSt;
         if (st == DECODE) isStore <= bus.opcode == OP_SW;
      end
   end
   always_comb begin
      nextSt = FETCH;
      case (st)
         FETCH:    nextSt = ready ? DECODE : FETCH;
         DECODE:
            case (bus.opcode)
               OP_LW, OP_SW: nextSt = MEMADR;
               OP_R:         nextSt = EXECUTE;
               OP_BEQ:       nextSt = BRANCH;
               OP_ADDI:      nextSt = ADDIEXEC;
               OP_ORI:       nextSt = ORIEXEC;
               OP_J:         nextSt = JUMP;
               default:      nextSt = FETCH;
            endcase
         MEMADR:   nextSt = isStore ? MEMWRITE : MEMREAD;
         MEMREAD:  nextSt = ready ? MEMWB : MEMREAD;
         MEMWRITE: nextSt = ready ? FETCH : MEMWRITE;
         EXECUTE:  nextSt = ALUWB;
         ADDIEXEC: nextSt = IMMWB;
         ORIEXEC:  nextSt = IMMWB;
         default:  nextSt = FETCH;
      endcase
   end
   always_comb begin
      bus.pcWrite = 1'b0;
      bus.pcWriteCond = 1'b0;
      bus.iorD = 1'b0;
      bus.memRead = 1'b0;
      bus.memWrite = 1'b0;
      bus.irWrite = 1'b0;
      bus.memToReg = 1'b0;
      bus.regDst = 1'b0;
      bus.regWrite = 1'b0;
      bus.aluSrcA = 1'b0;
      bus.illegalOp = 1'b0;
      bus.aluSrcB = 2'b00;
      bus.pcSource = 2'b00;
      bus.aluOp = 2'b00;
      case (st)
         FETCH: begin
            bus.memRead = 1'b1;
            bus.irWrite = ready;
            bus.pcWrite = ready;
            bus.aluSrcB = 2'b01;
         end
         DECODE: begin
            bus.aluSrcB = 2'b11;
            bus.illegalOp = !legalOp;
         end
         MEMADR: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b10;
         end
         MEMREAD: begin
            bus.memRead = 1'b1;
            bus.iorD = 1'b1;
         end
         MEMWB: begin
            bus.memToReg = 1'b1;
            bus.regWrite = 1'b1;
         end
         MEMWRITE: begin
            bus.memWrite = 1'b1;
            bus.iorD = 1'b1;
         end
         EXECUTE: begin
            bus.aluSrcA = 1'b1;
            bus.aluOp = 2'b10;
         end
         ALUWB: begin
            bus.regDst = 1'b1;
            bus.regWrite = 1'b1;
         end
         BRANCH: begin
            bus.aluSrcA = 1'b1;
            bus.aluOp = 2'b01;
            bus.pcWriteCond = 1'b1;
            bus.pcSource = 2'b01;
         end
         ADDIEXEC: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b10;
         end
         ORIEXEC: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = 2'b10;
            bus.aluOp = 2'b11;
         end
         IMMWB: bus.regWrite = 1'b1;
         JUMP: begin
            bus.pcWrite = 1'b1;
            bus.pcSource = 2'b10;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS main control unit. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath enables, the mux selects and the 2-bit `aluOp` code consumed by `aluControl`, so it is the producing end of the `aluOp` interface. It sits beside the instruction register and takes its opcode field as input.

## Interface
Parameters:
- none; state encoding is fixed (below).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instr[31:26] from the external IR; used only in DECODE.
- `memReady`  in  1  memory access complete. Used only when `MC_MEM_WAIT_EN` is defined.
- `pcWrite`, `pcWriteCond`, `iorD`, `memRead`, `memWrite`, `irWrite`, `memToReg`, `regDst`, `regWrite`, `aluSrcA`  out  1 each  datapath controls.
- `aluSrcB`  out  2  00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluOp`  out  2  00 = add, 01 = sub, 10 = use funct field, 11 = or.
- `illegalOp`  out  1  unsupported opcode seen in DECODE.
- `state`  out  4  current state code, for debug.

## Operation
- State codes: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEXEC=10, ORIEXEC=11, IMMWB=12, JUMP=13. Codes 14 and 15 are unreachable; if ever reached, the next state is FETCH.
- Every output not listed for a state is 0.
- INIT: all outputs 0. Next: FETCH.
- FETCH: `memRead`=1, `irWrite`=1, `pcWrite`=1, `aluSrcB`=01, `aluOp`=00. Next: DECODE.
- DECODE: `aluSrcB`=11, `aluOp`=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 001101 (ori) → ORIEXEC
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with `illegalOp`=1 for that DECODE cycle.
- MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `memRead`=1, `iorD`=1. Next: MEMWB.
- MEMWB: `memToReg`=1, `regWrite`=1. Next: FETCH.
- MEMWRITE: `memWrite`=1, `iorD`=1. Next: FETCH.
- EXECUTE: `aluSrcA`=1, `aluOp`=10. Next: ALUWB.
- ALUWB: `regDst`=1, `regWrite`=1. Next: FETCH.
- BRANCH: `aluSrcA`=1, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. Next: FETCH.
- ADDIEXEC: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Next: IMMWB.
- ORIEXEC: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=11. Next: IMMWB.
- IMMWB: `regWrite`=1. Next: FETCH.
- JUMP: `pcWrite`=1, `pcSource`=10. Next: FETCH.

## Timing
- `rst` high forces `state`=INIT immediately, with no clock edge needed, so every output reads 0.
- A reset asserted mid-instruction abandons that instruction; no partial write is issued after reset asserts.
- After `rst` falls, the first rising edge moves INIT to FETCH.
- Outputs decode from the registered state only. `illegalOp` and the DECODE next-state also depend on `opcode`.
- Cycles per instruction, counted from the FETCH cycle through the last state:
  - lw 5
  - sw 4, R-type 4, addi 4, ori 4
  - beq 3, j 3
  - illegal opcode 2.
- `opcode` must be stable from the edge ending FETCH through the DECODE cycle. It is ignored in every other state.

## Configuration
- Macro: `MC_MEM_WAIT_EN`.
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold until `memReady`=1. Each wait cycle adds one cycle to that state.
  - In FETCH, `irWrite` and `pcWrite` are asserted only in the cycle where `memReady`=1.
  - In MEMWRITE, `memWrite` stays 1 for the whole state.
  - `memRead` stays 1 for the whole of FETCH and MEMREAD.
- Not defined: `memReady` is ignored and every state lasts exactly one cycle.

## Test plan
- Reset: assert `rst` asynchronously in the middle of EXECUTE → `state`=0 and all outputs 0 before the next edge. After release: INIT, then FETCH (`memRead`=1, `irWrite`=1, `pcWrite`=1, `aluSrcB`=01).
- lw (100011): state sequence 1,2,3,4,5,1. Check `iorD`=1 in MEMREAD, and `memToReg`=1 with `regWrite`=1 in MEMWB.
- R-type (000000) then ori (001101):
  - `aluOp`=10 in EXECUTE and `aluOp`=11 in ORIEXEC.
  - `regDst`=1 in ALUWB and `regDst`=0 in IMMWB.
- beq (000100) then j (000010):
  - BRANCH drives `pcWriteCond`=1, `pcSource`=01, `aluOp`=01.
  - JUMP drives `pcWrite`=1, `pcSource`=10.
  - Each instruction takes 3 cycles.
- Opcode 111111 → `illegalOp`=1 for exactly one cycle during DECODE; next state FETCH; no write enable asserted.
- With `MC_MEM_WAIT_EN`, sw with `memReady` held low for 3 cycles → MEMWRITE lasts 4 cycles with `memWrite`=1 throughout, then FETCH.
